// File: rtl/shift_add_mul_ctrl_pkg.sv
// shift_add_mul_ctrl_pkg: shared widths, step count and state encoding
package shift_add_mul_ctrl_pkg;
   localparam int WIDTH      = 4;
   localparam int PWIDTH     = 8;
   localparam int CALC_STEPS = 4;
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_t;
endpackage

// File: rtl/shift_add_mul_ctrl_adder4.sv
// adder4: 4-bit ripple adder with carry out, built from half-adder cells
module half_adder (
   input  logic x,
   input  logic y,
   output logic s,
   output logic c
);
   assign s = x ^ y;
   assign c = x & y;
endmodule

module adder4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [4:0] sum
);
   logic [4:0] c;
   logic [3:0] s1, c1, c2;
   assign c[0] = 1'b0;
   for (genvar i = 0; i < 4; i++) begin : g_bit
      half_adder h0 (.x(a[i]), .y(b[i]), .s(s1[i]), .c(c1[i]));
      half_adder h1 (.x(s1[i]), .y(c[i]), .s(sum[i]), .c(c2[i]));
      assign c[i+1] = c1[i] | c2[i];
   end
   assign sum[4] = c[4];
endmodule

// File: rtl/shift_add_mul_ctrl.sv
// shift_add_mul_ctrl: sequential shift-and-add unsigned multiplier, 4 CALC cycles
module shift_add_mul_ctrl
   import shift_add_mul_ctrl_pkg::*;
#(
   parameter int W = WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   output logic             busy,
   output logic             done,
   output logic [2*W-1:0]   p
);
   state_t           state, state_nxt;
   logic [W-1:0]     mcand;
   logic [2*W-1:0]   acc, acc_nxt;
   logic [1:0]       step;
   logic [W:0]       sum;
   logic             last;

   adder4 u_add (.a(acc[2*W-1:W]), .b(acc[0] ? mcand : '0), .sum(sum));

   assign acc_nxt = {sum, acc[W-1:1]};
   assign last    = step == 2'(CALC_STEPS - 1);
   assign busy    = state == CALC;
   assign done    = state == DONE;

   // state register; reset and the unused encoding both land in IDLE
   always_ff @(posedge clk) begin
      state <= !rst_n ? IDLE : state_nxt;
   end

   // next state: accept start in IDLE, run CALC_STEPS steps, one DONE cycle
   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = start ? CALC : IDLE;
         CALC:    state_nxt = last ? DONE : CALC;
         default: state_nxt = IDLE;
      endcase
   end

   // datapath: load operands on accept, shift-add in CALC, latch product on last step
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand <= '0;
         acc   <= '0;
         step  <= '0;
         p     <= '0;
      end else if (state == IDLE && start) begin
         mcand <= a;
         acc   <= {{W{1'b0}}, b};
         step  <= '0;
      end else if (state == CALC) begin
         acc  <= acc_nxt;
         step <= step + 2'd1;
         if (last) p <= acc_nxt;
      end
   end
endmodule
